// File: rtl/regfile_sb_pkg.sv
// Shared constants for the scoreboarded register file.
// Default geometry plus the hard-wired zero register address.
package regfile_sb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

  localparam int ZERO_ADDR = 0;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write bits for every register plus the HI/LO pair.
// A reservation issued in the same cycle as a commit wins.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     HiWrite,
  input  logic                     LoWrite,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     issue_hilo,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     hilo_busy
);

  localparam int DEPTH = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO =
    ADDR_W'(ZERO_ADDR);

  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;
  logic             hilo_q;
  logic             hilo_d;
  logic             clr_en;
  logic             set_en;
  logic             hilo_clr;

  assign clr_en   = RegWrite && (wr_addr != ZERO);
  assign set_en   = issue_valid && (issue_addr != ZERO);
  assign hilo_clr = HiWrite || LoWrite;

  // Set is applied after clear so a new reservation survives.
  always_comb begin
    pend_d = pend_q;
    if (clr_en)
      pend_d[wr_addr] = 1'b0;
    if (set_en)
      pend_d[issue_addr] = 1'b1;
    pend_d[ZERO] = 1'b0;
  end

  assign hilo_d = issue_hilo || (hilo_q && !hilo_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      hilo_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      hilo_q <= hilo_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
    logic [ADDR_W-1:0] a;
    logic              hit;

    assign a   = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit = clr_en && (wr_addr == a);

    assign rd_busy[k] = !rst
                     && (a != ZERO)
                     && pend_q[a]
                     && !hit;
  end

  assign hilo_busy = !rst && hilo_q && !hilo_clr;

endmodule

// File: rtl/regfile_sb.sv
// Register file with HI/LO, same-cycle write bypass and a
// pending-write scoreboard for hazard detection.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     HiWrite,
  input  logic                     LoWrite,
  input  logic [DATA_W-1:0]        hi_data_in,
  input  logic [DATA_W-1:0]        lo_data_in,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     issue_hilo,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [DATA_W-1:0]        hi_data_out,
  output logic [DATA_W-1:0]        lo_data_out,
  output logic                     hilo_busy
);

  localparam int DEPTH = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO =
    ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic              wr_en;

  assign wr_en = RegWrite && (wr_addr != ZERO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (HiWrite)
        hi_q <= hi_data_in;
      if (LoWrite)
        lo_q <= lo_data_in;
    end
  end

  // Bypass is suppressed while reset is held.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;

    assign a = rd_addr[k*ADDR_W +: ADDR_W];

    assign rd_data[k*DATA_W +: DATA_W] =
      (rst || a == ZERO)        ? '0      :
      (wr_en && wr_addr == a)   ? wr_data :
                                  regs[a];
  end

  assign hi_data_out = rst     ? '0         :
                       HiWrite ? hi_data_in :
                                 hi_q;

  assign lo_data_out = rst     ? '0         :
                       LoWrite ? lo_data_in :
                                 lo_q;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .RegWrite    (RegWrite),
    .wr_addr     (wr_addr),
    .HiWrite     (HiWrite),
    .LoWrite     (LoWrite),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_hilo  (issue_hilo),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy),
    .hilo_busy   (hilo_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized scoreboard bench for regfile_sb against an
// associative-array model of registers and reservations.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          RegWrite = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          HiWrite = 1'b0;
  logic          LoWrite = 1'b0;
  logic [DW-1:0] hi_data_in = '0;
  logic [DW-1:0] lo_data_in = '0;
  logic          issue_valid = 1'b0;
  logic [AW-1:0] issue_addr = '0;
  logic          issue_hilo = 1'b0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [DW-1:0]    hi_data_out;
  logic [DW-1:0]    lo_data_out;
  logic             hilo_busy;

  always #5 clk = ~clk;

  regfile_sb #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWrite    (RegWrite),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .HiWrite     (HiWrite),
    .LoWrite     (LoWrite),
    .hi_data_in  (hi_data_in),
    .lo_data_in  (lo_data_in),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_hilo  (issue_hilo),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .hi_data_out (hi_data_out),
    .lo_data_out (lo_data_out),
    .hilo_busy   (hilo_busy)
  );

  typedef struct packed {
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    busy;
    logic [DW-1:0]    hi;
    logic [DW-1:0]    lo;
    logic             hb;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  logic [DW-1:0] m_reg [int];
  bit            m_res [int];
  logic [DW-1:0] m_hi;
  logic [DW-1:0] m_lo;
  bit            m_hres;

  task automatic check(input string n,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               n, act, req, $time);
    end
  endtask

  function automatic logic [DW-1:0] mread(input int a);
    if (m_reg.exists(a))
      return m_reg[a];
    return '0;
  endfunction

  task automatic drive(
    input bit r,
    input bit we, input int wa, input logic [DW-1:0] wd,
    input bit hw, input bit lw,
    input logic [DW-1:0] hd, input logic [DW-1:0] ld,
    input bit iv, input int ia, input bit ih,
    input int ra0, input int ra1);
    exp_t e;
    int   ra[NR];
    bit   byp;
    @(negedge clk);
    rst         = r;
    RegWrite    = we;
    wr_addr     = AW'(wa);
    wr_data     = wd;
    HiWrite     = hw;
    LoWrite     = lw;
    hi_data_in  = hd;
    lo_data_in  = ld;
    issue_valid = iv;
    issue_addr  = AW'(ia);
    issue_hilo  = ih;
    rd_addr     = {AW'(ra1), AW'(ra0)};
    ra[0] = ra0;
    ra[1] = ra1;
    e = '0;
    if (r) begin
      m_reg.delete();
      m_res.delete();
      m_hi   = '0;
      m_lo   = '0;
      m_hres = 1'b0;
      q.push_back(e);
    end else begin
      for (int k = 0; k < NR; k++) begin
        byp = we && wa == ra[k] && ra[k] != 0;
        if (ra[k] == 0)
          e.rd[k*DW +: DW] = '0;
        else if (byp)
          e.rd[k*DW +: DW] = wd;
        else
          e.rd[k*DW +: DW] = mread(ra[k]);
        e.busy[k] = ra[k] != 0 && m_res.exists(ra[k])
                    && !byp;
      end
      e.hi = hw ? hd : m_hi;
      e.lo = lw ? ld : m_lo;
      e.hb = m_hres && !(hw || lw);
      q.push_back(e);
      if (we && wa != 0) begin
        m_reg[wa] = wd;
        m_res.delete(wa);
      end
      if (iv && ia != 0)
        m_res[ia] = 1'b1;
      if (hw) m_hi = hd;
      if (lw) m_lo = ld;
      if (hw || lw) m_hres = 1'b0;
      if (ih) m_hres = 1'b1;
    end
  endtask

  task automatic idle(input int ra0, input int ra1);
    drive(0, 0, 0, '0, 0, 0, '0, '0, 0, 0, 0, ra0, ra1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        for (int k = 0; k < NR; k++) begin
          check($sformatf("rd_data%0d", k),
                rd_data[k*DW +: DW], e.rd[k*DW +: DW]);
          check($sformatf("rd_busy%0d", k),
                DW'(rd_busy[k]), DW'(e.busy[k]));
        end
        check("hi_out", hi_data_out, e.hi);
        check("lo_out", lo_data_out, e.lo);
        check("hilo_busy", DW'(hilo_busy), DW'(e.hb));
      end
    end
  end

  function automatic int raddr();
    if ($urandom_range(0, 3) == 0)
      return int'($urandom_range(0, 31));
    return int'($urandom_range(0, 6));
  endfunction

  initial begin : stim
    int wa;
    int ra0;
    int ra1;
    drive(1, 0, 0, '0, 0, 0, '0, '0, 0, 0, 0, 0, 31);
    drive(1, 0, 0, '0, 0, 0, '0, '0, 0, 0, 0, 0, 31);
    idle(0, 31);
    idle(31, 0);
    drive(0, 1, 5, 32'hDEADBEEF, 0, 0, '0, '0,
          0, 0, 0, 5, 0);
    idle(5, 5);
    drive(0, 0, 0, '0, 0, 0, '0, '0, 1, 7, 0, 7, 0);
    idle(7, 0);
    idle(0, 7);
    drive(0, 1, 7, 32'h0BADF00D, 0, 0, '0, '0,
          0, 0, 0, 7, 7);
    idle(7, 7);
    drive(0, 0, 0, '0, 0, 0, '0, '0, 1, 9, 0, 9, 0);
    drive(0, 1, 9, 32'h55AA55AA, 0, 0, '0, '0,
          1, 9, 0, 9, 9);
    idle(9, 9);
    drive(0, 0, 0, '0, 0, 0, '0, '0, 0, 0, 1, 0, 0);
    idle(0, 0);
    drive(0, 0, 0, '0, 1, 1, 32'h12345678, 32'h9ABCDEF0,
          0, 0, 0, 0, 0);
    idle(0, 0);
    drive(0, 1, 0, 32'hFFFFFFFF, 0, 0, '0, '0,
          1, 0, 0, 0, 0);
    idle(0, 0);
    drive(0, 0, 0, '0, 0, 0, '0, '0, 1, 3, 1, 3, 9);
    drive(0, 1, 4, 32'hCAFE0004, 0, 0, '0, '0,
          1, 6, 0, 4, 3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_busy", DW'(rd_busy), '0);
    check("async_hilo_busy", DW'(hilo_busy), '0);
    check("async_rd", rd_data[DW-1:0], '0);
    check("async_hi", hi_data_out, '0);
    drive(1, 1, 4, 32'h1111, 1, 1, 32'h2, 32'h3,
          1, 6, 1, 4, 6);
    idle(6, 4);
    idle(3, 9);
    for (int n = 0; n < 600; n++) begin
      wa  = raddr();
      ra0 = ($urandom_range(0, 2) == 0) ? wa : raddr();
      ra1 = ($urandom_range(0, 2) == 0) ? wa : raddr();
      drive($urandom_range(0, 59) == 0,
            $urandom_range(0, 1) == 1, wa, $urandom,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0,
            $urandom, $urandom,
            $urandom_range(0, 1) == 1, raddr(),
            $urandom_range(0, 5) == 0, ra0, ra1);
    end
    idle(0, 0);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
